// File: rtl/univ_shift_reg_seq.sv
// Universal shift/rotate register with a counted-step sequencer: one command
// (mode + step count) runs one single-bit step per clock, with busy/done status.
module univ_shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_left,
  input  logic             serial_right,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_left,
  output logic             ser_out_right,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHL  = 3'b001,
    M_SHR  = 3'b010,
    M_LOAD = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_ASR  = 3'b110,
    M_RSVD = 3'b111
  } mode_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  mode_e            cmd;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_d;
  logic             busy_d, done_d;

  // One single-bit step of the given mode; hold/load/reserved leave v as is.
  function automatic logic [WIDTH-1:0] step_fn(input mode_e m,
                                               input logic [WIDTH-1:0] v,
                                               input logic sl,
                                               input logic sr);
    case (m)
      M_SHL:   step_fn = {v[WIDTH-2:0], sr};
      M_SHR:   step_fn = {sl, v[WIDTH-1:1]};
      M_ROL:   step_fn = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:   step_fn = {v[0], v[WIDTH-1:1]};
      M_ASR:   step_fn = {v[WIDTH-1], v[WIDTH-1:1]};
      default: step_fn = v;
    endcase
  endfunction

  function automatic logic is_stepping(input mode_e m);
    return m inside {M_SHL, M_SHR, M_ROL, M_ROR, M_ASR};
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    q_d     = q;
    busy_d  = busy;
    done_d  = 1'b0;
    cmd     = mode_e'(mode);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cmd == M_LOAD) begin
            q_d    = parallel_in;
            done_d = 1'b1;
          end else if (is_stepping(cmd) && count != '0) begin
            q_d = step_fn(cmd, q, serial_left, serial_right);
            if (count == CNT_ONE) begin
              done_d = 1'b1;
            end else begin
              rem_d   = count - CNT_ONE;
              mode_d  = cmd;
              busy_d  = 1'b1;
              state_d = S_RUN;
            end
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Serial inputs are sampled live on each step; only the mode is latched.
        q_d   = step_fn(mode_q, q, serial_left, serial_right);
        rem_d = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_HOLD;
      rem_q   <= '0;
      q       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      q       <= q_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  assign ser_out_left  = q[WIDTH-1];
  assign ser_out_right = q[0];

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Scoreboard bench for univ_shift_reg_seq: stimulus pushes the expected final
// q and busy length per command; a monitor checks them on each done pulse.
module tb_univ_shift_reg_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_left;
  logic             serial_right;
  logic [WIDTH-1:0] q;
  logic             ser_out_left;
  logic             ser_out_right;
  logic             busy;
  logic             done;

  typedef struct {
    logic [WIDTH-1:0] q;
    int               busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt = 0;

  univ_shift_reg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .mode         (mode),
    .count        (count),
    .parallel_in  (parallel_in),
    .serial_left  (serial_left),
    .serial_right (serial_right),
    .q            (q),
    .ser_out_left (ser_out_left),
    .ser_out_right(ser_out_right),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_q", 32'(q), 32'(e.q));
          check("busy_cycles", 32'(busy_cnt), 32'(e.busy_cycles));
          check("ser_out_left", 32'(ser_out_left), 32'(e.q[WIDTH-1]));
          check("ser_out_right", 32'(ser_out_right), 32'(e.q[0]));
        end
        busy_cnt = 0;
      end
    end
  end

  // Called just after a rising edge; the command is accepted on the next edge.
  task automatic issue(input logic [2:0] m, input logic [CNT_W-1:0] n,
                       input logic [WIDTH-1:0] pin, input logic sl, input logic sr);
    start        = 1'b1;
    mode         = m;
    count        = n;
    parallel_in  = pin;
    serial_left  = sl;
    serial_right = sr;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] eq, input int bc);
    exp_t e;
    e.q = eq;
    e.busy_cycles = bc;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    mode         = 3'b000;
    count        = '0;
    parallel_in  = '0;
    serial_left  = 1'b0;
    serial_right = 1'b0;
    #1;
    check("reset_q", 32'(q), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Parallel load: count ignored, no busy.
    push(8'hA5, 0);
    issue(3'b011, 4'd7, 8'hA5, 1'b0, 1'b0);
    check("load_q", 32'(q), 32'hA5);
    drain(10);

    // Shift left by 3 with serial_right=1.
    push(8'h2F, 2);
    issue(3'b001, 4'd3, 8'h00, 1'b0, 1'b1);
    check("shl_step1", 32'(q), 32'h4B);
    @(posedge clk);
    #1 check("shl_step2", 32'(q), 32'h97);
    @(posedge clk);
    #1 check("shl_step3", 32'(q), 32'h2F);
    drain(10);

    // Back-to-back: load accepted, next start issued while done is high.
    push(8'h81, 0);
    push(8'hC0, 8);
    issue(3'b011, 4'd0, 8'h81, 1'b0, 1'b0);
    issue(3'b101, 4'd9, 8'h00, 1'b0, 1'b0);
    drain(20);

    // Arithmetic shift right by 2.
    push(8'h90, 0);
    push(8'hE4, 1);
    issue(3'b011, 4'd0, 8'h90, 1'b0, 1'b0);
    issue(3'b110, 4'd2, 8'h00, 1'b0, 1'b0);
    drain(10);

    // Count 0 on a shift mode: unchanged, done still pulses.
    push(8'hE4, 0);
    issue(3'b010, 4'd0, 8'h00, 1'b1, 1'b1);
    drain(10);

    // New start during RUN is ignored.
    push(8'h0F, 0);
    push(8'hF0, 3);
    issue(3'b011, 4'd0, 8'h0F, 1'b0, 1'b0);
    issue(3'b001, 4'd4, 8'h00, 1'b0, 1'b0);
    start = 1'b1; mode = 3'b011; count = 4'd1; parallel_in = 8'hFF;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    drain(10);

    // Hold and reserved modes complete immediately.
    push(8'hF0, 0);
    issue(3'b000, 4'd5, 8'h00, 1'b1, 1'b1);
    push(8'hF0, 0);
    issue(3'b111, 4'd5, 8'h00, 1'b1, 1'b1);
    drain(10);

    // Shift right with live serial_left, then single-step rotate left.
    push(8'hFC, 1);
    issue(3'b010, 4'd2, 8'h00, 1'b1, 1'b0);
    drain(10);
    push(8'hF9, 0);
    issue(3'b100, 4'd1, 8'h00, 1'b0, 1'b0);
    drain(10);

    // Asynchronous reset in the middle of a 9-step rotate left.
    push(8'h81, 0);
    issue(3'b011, 4'd0, 8'h81, 1'b0, 1'b0);
    drain(10);
    issue(3'b100, 4'd9, 8'h00, 1'b0, 1'b0);
    check("rol_step1", 32'(q), 32'h03);
    @(posedge clk);
    #1 check("rol_step2", 32'(q), 32'h06);
    @(posedge clk);
    #1 check("rol_step3", 32'(q), 32'h0C);
    check("rol_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrun_reset_q", 32'(q), 32'd0);
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_reset_q", 32'(q), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);

    // Block accepts commands again after the aborted one.
    push(8'h3C, 0);
    issue(3'b011, 4'd0, 8'h3C, 1'b0, 1'b0);
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_seq.md
# univ_shift_reg_seq

Parametrised, multi-mode shift register with a counted-shift sequencer. A single command (mode plus step count) is accepted on `start`. The block then runs the requested number of one-bit shifts or rotates, one per clock, with `busy` and `done` status. It is the generalised successor of the 5-bit universal shift register, for datapath and serialiser use where the shift distance is decided at run time.

## Interface
- `WIDTH`, 8, register width in bits (≥2)
- `CNT_W`, 4, width of the step-count input; counts above `WIDTH` are legal
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe; sampled only in IDLE
- `mode`  in  3  operation code, sampled with `start`
- `count`  in  CNT_W  number of one-bit steps, sampled with `start`
- `parallel_in`  in  WIDTH  load data
- `serial_left`  in  1  bit inserted at MSB on shift right
- `serial_right`  in  1  bit inserted at LSB on shift left
- `q`  out  WIDTH  register contents
- `ser_out_left`  out  1  `q[WIDTH-1]`, combinational
- `ser_out_right`  out  1  `q[0]`, combinational
- `busy`  out  1  high while steps remain after the accept edge
- `done`  out  1  one-cycle pulse marking completion of a command

## Operation
- Modes:
  - 000: hold
  - 001: shift left, `{q[W-2:0], serial_right}`
  - 010: shift right, `{serial_left, q[W-1:1]}`
  - 011: parallel load
  - 100: rotate left
  - 101: rotate right
  - 110: arithmetic shift right (MSB replicated)
  - 111: reserved, treated as hold
- States: IDLE, RUN. Reset enters IDLE with `q`=0, `busy`=0, `done`=0 and the step counter at 0.
- IDLE with `start`=1, accepted at that edge:
  - load: `q`<=`parallel_in`; `count` is ignored; `done`<=1; stay in IDLE.
  - hold or reserved: `q` unchanged; `done`<=1.
  - shift/rotate with `count`=0: `q` unchanged; `done`<=1.
  - shift/rotate with `count`=1: one step on this edge; `done`<=1; stay in IDLE.
  - shift/rotate with `count`=N>1: one step on this edge; latch mode; remaining <= N-1; `busy`<=1; go to RUN.
- RUN: one step per edge using the latched mode, and remaining decrements.
  - On the edge where remaining goes from 1 to 0: `busy`<=0, `done`<=1, go to IDLE.
- `serial_left` and `serial_right` are sampled live on every step edge, not latched at start.
- `start` is ignored while in RUN. New `mode`, `count` and `parallel_in` values have no effect during RUN.
- `done` is high for exactly one cycle per accepted command and is low otherwise.
- Rotates with N ≥ `WIDTH` wrap: the result equals rotate by N mod `WIDTH`, reached by N single steps.
- Asynchronous reset mid-RUN: `q`, `busy`, `done` and the counter clear immediately. The command is discarded.

## Timing
- Accept at edge k with N ≥ 1 steps: `q` changes on edges k … k+N-1.
- `busy` is high in the cycles after edges k … k+N-2 (N-1 cycles). It is never high for N ≤ 1.
- `done` is high in the cycle after edge k+N-1, or after edge k for load, hold, or N=0.
- Back-to-back: `start` may be asserted in the cycle `done` is high; it is accepted, since the block is in IDLE.
- Serial outputs follow `q` with no added latency.

## Test plan
- WIDTH=8, mode 100, count 9, `q`=0x81; pull `reset_n` low at the 4th step → `q`=0x00, `busy`=0, `done`=0 asynchronously, and no `done` pulse afterwards.
- Load: mode 011, `parallel_in`=0xA5, `start` → `q`=0xA5 after 1 edge, `done` high 1 cycle, `busy` never high.
- Shift left: `q`=0xA5, mode 001, count 3, `serial_right`=1 → `q`=0x4B, 0x97, 0x2F on successive edges; `busy` high 2 cycles; `done` high 1 cycle.
- Rotate right wrap: `q`=0x81, mode 101, count 9 → final `q`=0xC0 after 9 edges; `done` once.
- Arithmetic shift right: `q`=0x90, mode 110, count 2 → `q`=0xE4; `ser_out_left`=1, `ser_out_right`=0.
- Corner cases:
  - count 0 with mode 010 → `q` unchanged and `done` pulses.
  - `start` with new mode/count during RUN → ignored; the original command completes unchanged.
